operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
Upstream neighbour of the ALU: holds the 32-entry integer register file and produces registered ALUop1/ALUop2/ALUctrl for the execute stage. It accepts one decoded instruction per cycle over a valid/ready handshake and selects rs2 or the immediate for operand 2. It also takes the write-back port (rd, data, enable) from the end of the pipe.

Parameters:
DATA_WIDTH, 32, width of registers, operands, immediate and write-back data
ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  decoded instruction fields valid this cycle
in_ready  output  1  stage can accept an instruction this cycle
rs1  input  ADDR_WIDTH  source register 1 index
rs2  input  ADDR_WIDTH  source register 2 index
imm  input  DATA_WIDTH  sign-extended immediate from decode
ALUsrc  input  1  0: operand 2 = reg[rs2]; 1: operand 2 = imm
ctrl_in  input  1  ALU operation (0 add, 1 compare-equal), passed through
wr_en  input  1  write-back enable
rd  input  ADDR_WIDTH  write-back destination index
wr_data  input  DATA_WIDTH  write-back data
ALUop1  output  DATA_WIDTH  registered operand 1 to ALU
ALUop2  output  DATA_WIDTH  registered operand 2 to ALU
ALUctrl  output  1  registered ALU operation
out_valid  output  1  ALUop1/ALUop2/ALUctrl hold a valid instruction
out_ready  input  1  execute stage consumes the output this cycle
a0  output  DATA_WIDTH  live content of register 10, for test/observation

Behaviour:
- Reset: synchronous; on a clk edge with rst=1, every register file entry clears to 0, out_valid=0, ALUop1=0, ALUop2=0, ALUctrl=0. rst takes priority over writes and captures in the same cycle. A reset mid-stream drops the in-flight instruction, and out_valid is 0 on the next cycle.
- Register file: 2**ADDR_WIDTH x DATA_WIDTH; two combinational read ports indexed by rs1 and rs2; one synchronous write port.
- Write: on a clk edge with wr_en=1 and rd!=0, reg[rd] <= wr_data. Writes to index 0 are discarded, and reads of index 0 always return 0.
- Handshake: in_ready = !out_valid || out_ready (combinational; single pipeline register, no skid buffer).
- Capture: on an edge with in_valid && in_ready:
  - ALUop1 <= reg[rs1]
  - ALUop2 <= ALUsrc ? imm : reg[rs2]
  - ALUctrl <= ctrl_in
  - out_valid <= 1
- Drain: on an edge with out_valid && out_ready && !in_valid, out_valid <= 0. Operand registers keep their old values.
- Stall: out_valid && !out_ready means all output registers hold. in_ready=0 and the input is not consumed, so upstream must hold its fields.
- Latency: 1 cycle from accepted input to out_valid. Throughput: 1 per cycle while out_ready=1.
- Write-back and capture are independent; both may occur on the same edge.
- Same-edge read/write hazard (wr_en=1, rd==rs1 or rd==rs2, rd!=0, capture on that edge): behaviour is set by the Optional Feature.
- Width: no arithmetic in this block. imm arrives already DATA_WIDTH and is not extended here.
- a0 reflects reg[10] after any write, with one edge of latency.

Optional Feature:
Macro OPERAND_FETCH_BYPASS_EN.
- Defined: a capture on the same edge as a matching write takes wr_data for that operand (write-through forwarding). Index 0 is never forwarded. The imm path is unaffected when ALUsrc=1.
- Undefined: the captured operand is the pre-write (old) register value. Software/hazard logic must insert one bubble.

Decomposition:
- Shared package cpu_pkg: DATA_WIDTH/ADDR_WIDTH defaults, ALU op constants (ALU_ADD=1'b0, ALU_EQ=1'b1), REG_ZERO=0, REG_A0=10.
- One natural sub-module, reg_file: array, 2 read ports, 1 write port, x0 rule, a0 tap.
- operand_fetch instantiates reg_file and adds the mux, the handshake and the pipeline register.

Test Plan:
- Reset: rst=1 for 1 cycle -> out_valid=0, ALUop1=ALUop2=0, a0=0; then read rs1=5 -> ALUop1=0.
- Write/read: wr_en=1 rd=3 wr_data=0x0000_00AA; next cycle capture rs1=3 rs2=0 ALUsrc=0 -> ALUop1=0xAA, ALUop2=0, out_valid=1 one cycle later.
- x0 write: wr_en=1 rd=0 wr_data=0xFFFF_FFFF, then read rs1=0 -> ALUop1=0. Also write rd=10 data=7 -> a0=7.
- Immediate: reg[4]=9, rs1=4 ALUsrc=1 imm=0xFFFF_FFFC ctrl_in=0 -> ALUop1=9, ALUop2=0xFFFF_FFFC, ALUctrl=0.
- Stall: out_valid=1, out_ready=0 for 3 cycles with new in_valid -> in_ready=0 and outputs unchanged. Then out_ready=1 -> the new instruction is captured next edge.
- Hazard: reg[6]=1, same edge wr_en=1 rd=6 wr_data=2 and capture rs1=6 -> ALUop1=2 with OPERAND_FETCH_BYPASS_EN, ALUop1=1 without. Also rst=1 coincident with capture -> out_valid=0 and reg[6]=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath widths, ALU operation codes and
// architectural register indices used by the operand-fetch slice.
package cpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_EQ  = 1'b1;

  localparam int REG_ZERO = 0;
  localparam int REG_A0   = 10;

  // True when a write-back to rd lands on a source register this edge; x0 never matches.
  function automatic logic wb_hits(input logic wr_en, input logic [ADDR_WIDTH-1:0] rd,
                                   input logic [ADDR_WIDTH-1:0] rs);
    return wr_en && (rd != ADDR_WIDTH'(REG_ZERO)) && (rd == rs);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode/write-back/execute bus of the operand-fetch stage. The master side
// is the pipeline around the stage, the slave side is operand_fetch itself.
interface operand_fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  // decode side
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [DATA_WIDTH-1:0] imm;
  logic                  ALUsrc;
  logic                  ctrl_in;

  // write-back side
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] wr_data;

  // execute side
  logic [DATA_WIDTH-1:0] ALUop1;
  logic [DATA_WIDTH-1:0] ALUop2;
  logic                  ALUctrl;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_valid, rs1, rs2, imm, ALUsrc, ctrl_in,
    output wr_en, rd, wr_data,
    output out_ready,
    input  in_ready, ALUop1, ALUop2, ALUctrl, out_valid
  );

  modport slave (
    input  in_valid, rs1, rs2, imm, ALUsrc, ctrl_in,
    input  wr_en, rd, wr_data,
    input  out_ready,
    output in_ready, ALUop1, ALUop2, ALUctrl, out_valid
  );

endinterface

// File: rtl/reg_file.sv
// Integer register file: 2**ADDR_WIDTH entries, two combinational read ports,
// one synchronous write port, hard-wired x0 and an a0 observation tap.
module reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // NOTE: the array is built from resettable flops rather than a RAM macro,
  // because the architecture requires every register to read 0 after reset.
  // NOTE: sequential state uses non-blocking assignments so every reader in
  // the same edge sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (rd != IDX_ZERO)) begin
      regs[rd] <= wr_data;
    end
  end

  assign rdata1 = (rs1 == IDX_ZERO) ? '0 : regs[rs1];
  assign rdata2 = (rs2 == IDX_ZERO) ? '0 : regs[rs2];
  assign a0     = regs[REG_A0];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file read, operand-2 select and a single
// valid/ready pipeline register feeding the ALU. OPERAND_FETCH_BYPASS_EN
// enables write-through forwarding of same-edge write-back data.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_fetch_if.slave        bus,
  output logic [DATA_WIDTH-1:0] a0
);

  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic [DATA_WIDTH-1:0] op1_next;
  logic [DATA_WIDTH-1:0] op2_next;
  logic                  capture;

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .rd      (bus.rd),
    .wr_data (bus.wr_data),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .a0      (a0)
  );

  // Single pipeline register without skid buffer: accept whenever the slot
  // is empty or is being drained this cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    op1_next = rdata1;
    op2_next = bus.ALUsrc ? bus.imm : rdata2;
`ifdef OPERAND_FETCH_BYPASS_EN
    if (wb_hits(bus.wr_en, bus.rd, bus.rs1)) begin
      op1_next = bus.wr_data;
    end
    if (!bus.ALUsrc && wb_hits(bus.wr_en, bus.rd, bus.rs2)) begin
      op2_next = bus.wr_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.ALUop1    <= '0;
      bus.ALUop2    <= '0;
      bus.ALUctrl   <= ALU_ADD;
    end else if (capture) begin
      bus.out_valid <= 1'b1;
      bus.ALUop1    <= op1_next;
      bus.ALUop2    <= op2_next;
      bus.ALUctrl   <= bus.ctrl_in;
    end else if (bus.out_ready) begin
      // Drain: operands keep their stale values, only the valid flag drops.
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch: reset, write/read, x0,
// immediate select, stall/drain, same-edge hazard and reset during capture.
module tb_operand_fetch;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] a0;

  int n_checks;
  int n_errors;

  operand_fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  operand_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .a0  (a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic valid, input logic [4:0] s1, input logic [4:0] s2,
                          input logic src, input logic [31:0] im, input logic op);
    bus.in_valid = valid;
    bus.rs1      = s1;
    bus.rs2      = s2;
    bus.ALUsrc   = src;
    bus.imm      = im;
    bus.ctrl_in  = op;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] idx, input logic [31:0] data);
    bus.wr_en   = en;
    bus.rd      = idx;
    bus.wr_data = data;
  endtask

  logic [31:0] hz_exp;

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef OPERAND_FETCH_BYPASS_EN
    hz_exp = 32'd2;
`else
    hz_exp = 32'd1;
`endif
    rst = 1'b1;
    drive_in(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_ADD);
    drive_wb(1'b0, 5'd0, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_op1", bus.ALUop1, 32'd0);
    check("rst_op2", bus.ALUop2, 32'd0);
    check("rst_ctrl", 32'(bus.ALUctrl), 32'd0);
    check("rst_a0", a0, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    drive_in(1'b1, 5'd5, 5'd0, 1'b0, 32'h0, ALU_ADD);
    tick();
    check("rd5_op1", bus.ALUop1, 32'd0);
    check("rd5_valid", 32'(bus.out_valid), 32'd1);

    // Write reg3, drain the previous output in the same cycle
    drive_in(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_ADD);
    drive_wb(1'b1, 5'd3, 32'h0000_00AA);
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_in(1'b1, 5'd3, 5'd0, 1'b0, 32'h0, ALU_ADD);
    tick();
    check("wr3_op1", bus.ALUop1, 32'h0000_00AA);
    check("wr3_op2", bus.ALUop2, 32'd0);
    check("wr3_valid", 32'(bus.out_valid), 32'd1);

    // Read reg3 through port 2, compare-equal op
    drive_in(1'b1, 5'd0, 5'd3, 1'b0, 32'h0, ALU_EQ);
    tick();
    check("rs2_op1", bus.ALUop1, 32'd0);
    check("rs2_op2", bus.ALUop2, 32'h0000_00AA);
    check("rs2_ctrl", 32'(bus.ALUctrl), 32'd1);

    // x0 write discarded; a0 tap
    drive_in(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_ADD);
    drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    drive_wb(1'b1, 5'd10, 32'd7);
    drive_in(1'b1, 5'd0, 5'd0, 1'b0, 32'h0, ALU_ADD);
    tick();
    check("x0_op1", bus.ALUop1, 32'd0);
    check("a0_tap", a0, 32'd7);

    // Immediate select
    drive_in(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_ADD);
    drive_wb(1'b1, 5'd4, 32'd9);
    tick();
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_in(1'b1, 5'd4, 5'd3, 1'b1, 32'hFFFF_FFFC, ALU_ADD);
    tick();
    check("imm_op1", bus.ALUop1, 32'd9);
    check("imm_op2", bus.ALUop2, 32'hFFFF_FFFC);
    check("imm_ctrl", 32'(bus.ALUctrl), 32'd0);

    // Stall: new instruction waits while execute is not ready
    bus.out_ready = 1'b0;
    drive_in(1'b1, 5'd3, 5'd4, 1'b0, 32'h0, ALU_EQ);
    #1;
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_op1", i), bus.ALUop1, 32'd9);
      check($sformatf("stall%0d_op2", i), bus.ALUop2, 32'hFFFF_FFFC);
      check($sformatf("stall%0d_ctrl", i), 32'(bus.ALUctrl), 32'd0);
      check($sformatf("stall%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("stall%0d_ready", i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("unstall_op1", bus.ALUop1, 32'h0000_00AA);
    check("unstall_op2", bus.ALUop2, 32'd9);
    check("unstall_ctrl", 32'(bus.ALUctrl), 32'd1);

    // Drain keeps operands
    drive_in(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_ADD);
    tick();
    check("drain2_valid", 32'(bus.out_valid), 32'd0);
    check("drain2_op1_hold", bus.ALUop1, 32'h0000_00AA);

    // Same-edge hazard on reg6
    drive_wb(1'b1, 5'd6, 32'd1);
    tick();
    drive_wb(1'b1, 5'd6, 32'd2);
    drive_in(1'b1, 5'd6, 5'd6, 1'b0, 32'h0, ALU_ADD);
    tick();
    check("hz_op1", bus.ALUop1, hz_exp);
    check("hz_op2", bus.ALUop2, hz_exp);
    drive_wb(1'b0, 5'd0, 32'h0);
    tick();
    check("hz_after_op1", bus.ALUop1, 32'd2);

    // Immediate path is never forwarded; x0 never forwarded
    drive_wb(1'b1, 5'd6, 32'd5);
    drive_in(1'b1, 5'd0, 5'd6, 1'b1, 32'h0000_0123, ALU_ADD);
    tick();
    check("hz_imm_op2", bus.ALUop2, 32'h0000_0123);
    drive_wb(1'b1, 5'd0, 32'h0000_0055);
    drive_in(1'b1, 5'd0, 5'd0, 1'b0, 32'h0, ALU_ADD);
    tick();
    check("hz_x0_op1", bus.ALUop1, 32'd0);
    check("hz_x0_op2", bus.ALUop2, 32'd0);

    // Reset coincident with capture and with a write to a0
    rst = 1'b1;
    drive_wb(1'b1, 5'd10, 32'd9);
    drive_in(1'b1, 5'd6, 5'd4, 1'b0, 32'h0, ALU_EQ);
    tick();
    rst = 1'b0;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_in(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_ADD);
    check("rst2_valid", 32'(bus.out_valid), 32'd0);
    check("rst2_op1", bus.ALUop1, 32'd0);
    check("rst2_ctrl", 32'(bus.ALUctrl), 32'd0);
    check("rst2_a0", a0, 32'd0);
    drive_in(1'b1, 5'd6, 5'd4, 1'b0, 32'h0, ALU_ADD);
    tick();
    check("rst2_reg6", bus.ALUop1, 32'd0);
    check("rst2_reg4", bus.ALUop2, 32'd0);
    check("rst2_cap_valid", 32'(bus.out_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
